// File: rtl/kart_pkg.sv
// Shared types and constants for the kart physics block.
package kart_pkg;

    typedef enum logic [1:0] {
        T_ROAD   = 2'd0,
        T_GRASS  = 2'd1,
        T_WALL   = 2'd2,
        T_FINISH = 2'd3
    } terrain_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEER,
        S_ACCEL,
        S_PROPOSE,
        S_WAIT_T,
        S_COMMIT
    } phys_state_t;

    localparam int WORLD_MAX    = 2047;
    localparam int BOOST_FRAMES = 64;
    localparam int BOOST_BONUS  = 4;

endpackage

// File: rtl/heading_lut.sv
// Maps a 16-direction heading (0 = +x, clockwise) to a signed unit vector scaled by 8.
module heading_lut (
    input  logic [3:0]        heading,
    output logic signed [4:0] vx,
    output logic signed [4:0] vy
);

    function automatic logic signed [4:0] cos16(input logic [3:0] k);
        case (k)
            4'd0:         return 5'sd8;
            4'd1, 4'd15:  return 5'sd7;
            4'd2, 4'd14:  return 5'sd6;
            4'd3, 4'd13:  return 5'sd3;
            4'd5, 4'd11:  return -5'sd3;
            4'd6, 4'd10:  return -5'sd6;
            4'd7, 4'd9:   return -5'sd7;
            4'd8:         return -5'sd8;
            default:      return 5'sd0;
        endcase
    endfunction

    // sin(k) equals cos(k - quarter turn), so one table serves both axes
    assign vx = cos16(heading);
    assign vy = cos16(heading - 4'd4);

endmodule

// File: rtl/kart_physics.sv
// Kart physics: per-frame steer, accelerate, propose, terrain lookup and commit.
// Optional boost feature is enabled by defining KART_BOOST_EN.
module kart_physics
    import kart_pkg::*;
#(
    parameter int START_X         = 1960,
    parameter int START_Y         = 1960,
    parameter int MAX_SPEED       = 12,
    parameter int OFFROAD_MAX     = 4,
    parameter int TERRAIN_TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        gas_in,
    input  logic        brake_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        boost_in,
    output logic        terrain_req_out,
    output logic [10:0] terrain_x_out,
    output logic [10:0] terrain_y_out,
    input  logic        terrain_valid_in,
    input  logic [1:0]  terrain_in,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [3:0]  heading_out,
    output logic [4:0]  speed_out,
    output logic [1:0]  lap_out,
    output logic        pos_valid_out,
    output logic        boost_active_out
);

    localparam int WAIT_W = $clog2(TERRAIN_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TERRAIN_TIMEOUT - 1);

    phys_state_t        state;
    terrain_t           prev_terrain;
    terrain_t           seen_terrain;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               boost_on;
    logic signed [4:0]  vx, vy;
    logic signed [6:0]  accel_delta;
    logic [4:0]         speed_cap;
    logic signed [10:0] prod_x, prod_y;
    logic signed [12:0] sum_x, sum_y;

    function automatic logic [4:0] sat_speed(input logic signed [6:0] raw, input logic [4:0] cap);
        if (raw < 7'sd0) return 5'd0;
        if (raw > $signed({2'b00, cap})) return cap;
        return raw[4:0];
    endfunction

    function automatic logic [10:0] clamp_world(input logic signed [12:0] v);
        if (v < 13'sd0) return 11'd0;
        if (v > 13'(WORLD_MAX)) return 11'(WORLD_MAX);
        return v[10:0];
    endfunction

    heading_lut u_heading_lut (
        .heading (heading_out),
        .vx      (vx),
        .vy      (vy)
    );

`ifdef KART_BOOST_EN
    logic [6:0] boost_cnt;

    // Counts frame ticks regardless of FSM state; a new request restarts the window
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            boost_cnt <= 7'd0;
        end else if (boost_in) begin
            boost_cnt <= 7'(BOOST_FRAMES);
        end else if (frame_tick_in && boost_cnt != 7'd0) begin
            boost_cnt <= boost_cnt - 7'd1;
        end
    end

    assign boost_on = (boost_cnt != 7'd0);
`else
    logic boost_unused;
    assign boost_unused = boost_in;
    assign boost_on     = 1'b0;
`endif

    assign boost_active_out = boost_on;

    always_comb begin
        accel_delta = -7'sd1;
        if (gas_in && !brake_in) accel_delta = 7'sd1;
        else if (brake_in && !gas_in) accel_delta = -7'sd2;
        if (boost_on) accel_delta = accel_delta + 7'sd2;
    end

    always_comb begin
        speed_cap = 5'(MAX_SPEED);
        if (prev_terrain == T_GRASS) speed_cap = 5'(OFFROAD_MAX);
        else if (boost_on) speed_cap = 5'(MAX_SPEED + BOOST_BONUS);
    end

    assign prod_x = 11'(vx) * 11'($signed({1'b0, speed_out}));
    assign prod_y = 11'(vy) * 11'($signed({1'b0, speed_out}));
    assign sum_x  = $signed({2'b00, player_x}) + 13'(prod_x >>> 3);
    assign sum_y  = $signed({2'b00, player_y}) + 13'(prod_y >>> 3);

    assign seen_terrain = terrain_valid_in ? terrain_t'(terrain_in) : T_WALL;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            player_x        <= 11'(START_X);
            player_y        <= 11'(START_Y);
            terrain_x_out   <= 11'(START_X);
            terrain_y_out   <= 11'(START_Y);
            heading_out     <= 4'd0;
            speed_out       <= 5'd0;
            lap_out         <= 2'd0;
            terrain_req_out <= 1'b0;
            pos_valid_out   <= 1'b0;
            prev_terrain    <= T_ROAD;
            wait_cnt        <= '0;
        end else begin
            pos_valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_tick_in) state <= S_STEER;
                end
                S_STEER: begin
                    if (left_in && !right_in) heading_out <= heading_out - 4'd1;
                    else if (right_in && !left_in) heading_out <= heading_out + 4'd1;
                    state <= S_ACCEL;
                end
                S_ACCEL: begin
                    speed_out <= sat_speed($signed({2'b00, speed_out}) + accel_delta, speed_cap);
                    state     <= S_PROPOSE;
                end
                S_PROPOSE: begin
                    terrain_x_out   <= clamp_world(sum_x);
                    terrain_y_out   <= clamp_world(sum_y);
                    terrain_req_out <= 1'b1;
                    wait_cnt        <= '0;
                    state           <= S_WAIT_T;
                end
                S_WAIT_T: begin
                    // Commit results land with the pulse so they are visible during COMMIT
                    if (terrain_valid_in || wait_cnt == WAIT_LAST) begin
                        terrain_req_out <= 1'b0;
                        pos_valid_out   <= 1'b1;
                        prev_terrain    <= seen_terrain;
                        state           <= S_COMMIT;
                        if (seen_terrain == T_WALL) begin
                            speed_out <= 5'd0;
                        end else begin
                            player_x <= terrain_x_out;
                            player_y <= terrain_y_out;
                        end
                        if (seen_terrain == T_FINISH && prev_terrain != T_FINISH && lap_out != 2'd3)
                            lap_out <= lap_out + 2'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kart_physics.sv
// Directed and randomized bench for kart_physics against a frame-level reference model.
module tb_kart_physics;
    import kart_pkg::*;

    localparam int MAXS = 12;
    localparam int OFFM = 4;
    localparam int TMO  = 16;
    localparam int SX   = 1960;
    localparam int SY   = 1960;
`ifdef KART_BOOST_EN
    localparam bit BOOST_EN = 1'b1;
`else
    localparam bit BOOST_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, frame_tick_in, gas_in, brake_in, left_in, right_in, boost_in;
    logic        terrain_valid_in;
    logic [1:0]  terrain_in;
    logic        terrain_req_out, pos_valid_out, boost_active_out;
    logic [10:0] terrain_x_out, terrain_y_out, player_x, player_y;
    logic [3:0]  heading_out;
    logic [4:0]  speed_out;
    logic [1:0]  lap_out;

    int checks   = 0;
    int failures = 0;
    int m_x, m_y, m_head, m_speed, m_lap, m_prev, m_boost;

    always #5 clk_in = ~clk_in;

    kart_physics dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_tick_in    (frame_tick_in),
        .gas_in           (gas_in),
        .brake_in         (brake_in),
        .left_in          (left_in),
        .right_in         (right_in),
        .boost_in         (boost_in),
        .terrain_req_out  (terrain_req_out),
        .terrain_x_out    (terrain_x_out),
        .terrain_y_out    (terrain_y_out),
        .terrain_valid_in (terrain_valid_in),
        .terrain_in       (terrain_in),
        .player_x         (player_x),
        .player_y         (player_y),
        .heading_out      (heading_out),
        .speed_out        (speed_out),
        .lap_out          (lap_out),
        .pos_valid_out    (pos_valid_out),
        .boost_active_out (boost_active_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Unit vector from trigonometry, rounded to nearest, scaled by 8
    function automatic int unit_vec(input int k, input bit is_y);
        real ang, v;
        ang = k * 3.14159265358979 / 8.0;
        v   = is_y ? 8.0 * $sin(ang) : 8.0 * $cos(ang);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic int clampw(input int v);
        return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
    endfunction

    task automatic model_reset();
        m_x = SX; m_y = SY; m_head = 0; m_speed = 0; m_lap = 0; m_prev = 0; m_boost = 0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_x"}, player_x, m_x);
        chk({pfx, "_y"}, player_y, m_y);
        chk({pfx, "_head"}, heading_out, m_head);
        chk({pfx, "_speed"}, speed_out, m_speed);
        chk({pfx, "_lap"}, lap_out, m_lap);
        chk({pfx, "_boost"}, boost_active_out, (m_boost > 0));
    endtask

    task automatic pulse_boost();
        boost_in = 1'b1;
        @(posedge clk_in); #1;
        boost_in = 1'b0;
        if (BOOST_EN) m_boost = 64;
    endtask

    // One full frame: dly < TMO answers in WAIT_T cycle dly, otherwise the lookup times out
    task automatic do_frame(input bit g, input bit b, input bit l, input bit r,
                            input int terr, input int dly, input bit noise);
        int cyc, s, delta, cap, cx, cy, eff, expn;
        bit timed_out, stable;
        gas_in = g; brake_in = b; left_in = l; right_in = r;
        if (BOOST_EN && m_boost > 0) m_boost--;
        if (l && !r) m_head = (m_head + 15) % 16;
        else if (r && !l) m_head = (m_head + 1) % 16;
        delta = (g && !b) ? 1 : ((b && !g) ? -2 : -1);
        if (m_boost > 0) delta += 2;
        cap = (m_prev == 1) ? OFFM : ((m_boost > 0) ? MAXS + 4 : MAXS);
        s = m_speed + delta;
        if (s < 0) s = 0;
        if (s > cap) s = cap;
        cx = clampw(m_x + $rtoi($floor(unit_vec(m_head, 1'b0) * s / 8.0)));
        cy = clampw(m_y + $rtoi($floor(unit_vec(m_head, 1'b1) * s / 8.0)));
        timed_out = (dly >= TMO);
        expn = timed_out ? TMO : dly + 1;
        eff  = timed_out ? 2 : terr;

        frame_tick_in = 1'b1;
        if (noise) begin terrain_valid_in = 1'b1; terrain_in = 2'd2; end
        @(posedge clk_in); #1;
        frame_tick_in = 1'b0;
        cyc = 1;
        while (cyc < 4) begin
            frame_tick_in = noise && (cyc == 3);
            @(posedge clk_in); #1;
            cyc++;
        end
        frame_tick_in = 1'b0;
        terrain_valid_in = 1'b0;
        if (noise && m_boost > 0) m_boost--;
        chk("req_on_entry", terrain_req_out, 1);
        chk("cand_x", terrain_x_out, cx);
        chk("cand_y", terrain_y_out, cy);

        stable = 1'b1;
        while (!pos_valid_out && cyc < 4 + TMO + 4) begin
            if (terrain_req_out !== 1'b1 || terrain_x_out !== 11'(cx) || terrain_y_out !== 11'(cy))
                stable = 1'b0;
            if (!timed_out && cyc == 4 + dly) begin
                terrain_valid_in = 1'b1;
                terrain_in = 2'(terr);
            end else begin
                terrain_valid_in = 1'b0;
                terrain_in = 2'($urandom_range(0, 3));
            end
            @(posedge clk_in); #1;
            cyc++;
        end
        terrain_valid_in = 1'b0;
        chk("req_hold", stable, 1);
        chk("latency", cyc, 4 + expn);

        if (eff == 2) s = 0;
        else begin m_x = cx; m_y = cy; end
        m_speed = s;
        if (eff == 3 && m_prev != 3 && m_lap < 3) m_lap++;
        m_prev = eff;
        check_outputs("commit");
        chk("req_after", terrain_req_out, 0);
        @(posedge clk_in); #1;
        chk("pv_pulse", pos_valid_out, 0);
    endtask

    initial begin
        int px, py, seen;
        int lap_seq [5];
        int lap_exp [5];
        rst_in = 1'b1; frame_tick_in = 0; gas_in = 0; brake_in = 0; left_in = 0; right_in = 0;
        boost_in = 0; terrain_valid_in = 0; terrain_in = 2'd0;
        repeat (3) @(posedge clk_in);
        #1;
        model_reset();
        check_outputs("reset");
        chk("reset_req", terrain_req_out, 0);
        chk("reset_pv", pos_valid_out, 0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Idle frame on road
        do_frame(0, 0, 0, 0, 0, 0, 0);
        chk("s1_x", player_x, 1960);
        chk("s1_y", player_y, 1960);
        chk("s1_speed", speed_out, 0);

        // Head west to make room, stop, turn back east, then accelerate to the cap
        repeat (8) do_frame(0, 0, 0, 1, 0, $urandom_range(0, 3), 1);
        chk("s2_turn", heading_out, 8);
        repeat (40) do_frame(1, 0, 0, 0, 0, $urandom_range(0, 3), 0);
        repeat (6) do_frame(0, 1, 0, 0, 0, 0, 0);
        chk("s2_stopped", speed_out, 0);
        repeat (8) do_frame(0, 0, 1, 0, 0, 0, 0);
        chk("s2_head0", heading_out, 0);
        px = 0;
        for (int i = 0; i < 20; i++) begin
            px = int'(player_x);
            do_frame(1, 0, 0, 0, 0, 1, 0);
        end
        chk("s2_speed", speed_out, 12);
        chk("s2_dx", int'(player_x) - px, 12);

        // Wall at full speed
        px = int'(player_x); py = int'(player_y);
        do_frame(1, 0, 0, 0, 2, 2, 0);
        chk("s3_x", player_x, px);
        chk("s3_y", player_y, py);
        chk("s3_speed", speed_out, 0);

        // Grass cap, then a withheld lookup
        do_frame(1, 0, 0, 0, 1, 0, 0);
        repeat (6) do_frame(1, 0, 0, 0, 1, $urandom_range(0, 5), 0);
        chk("s4_cap", speed_out, 4);
        px = int'(player_x);
        do_frame(1, 0, 0, 0, 1, 99, 0);
        chk("s4_to_x", player_x, px);
        chk("s4_to_speed", speed_out, 0);

        // Lap counting
        lap_seq = '{0, 3, 3, 0, 3};
        lap_exp = '{0, 1, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin
            do_frame(0, 0, 0, 0, lap_seq[i], i, 0);
            chk("s5_lap", lap_out, lap_exp[i]);
        end
        repeat (3) begin
            do_frame(0, 0, 0, 0, 0, 0, 0);
            do_frame(0, 0, 0, 0, 3, 0, 0);
        end
        chk("s5_sat", lap_out, 3);

        // Reset while waiting for terrain
        gas_in = 1'b1; right_in = 1'b1;
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1;
        frame_tick_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        chk("s6_in_wait", terrain_req_out, 1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; gas_in = 1'b0; right_in = 1'b0;
        model_reset();
        check_outputs("s6_rst");
        seen = 0;
        repeat (24) begin
            terrain_valid_in = 1'b1; terrain_in = 2'd0;
            @(posedge clk_in); #1;
            if (pos_valid_out) seen = 1;
        end
        terrain_valid_in = 1'b0;
        chk("s6_nocommit", seen, 0);
        chk("s6_req", terrain_req_out, 0);
        check_outputs("s6_idle");
        do_frame(0, 0, 0, 0, 0, 0, 0);

        // Boost window
        repeat (14) do_frame(1, 0, 0, 0, 0, 0, 0);
        pulse_boost();
        repeat (4) do_frame(1, 0, 0, 0, 0, 0, 0);
        chk("s7_speed", speed_out, BOOST_EN ? 16 : 12);
        repeat (59) do_frame(1, 0, 0, 0, 0, 0, 0);
        chk("s7_active", boost_active_out, BOOST_EN);
        do_frame(1, 0, 0, 0, 0, 0, 0);
        chk("s7_drop", boost_active_out, 0);

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) pulse_boost();
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kart_physics.md
KART_PHYSICS -- requirements
Module: kart_physics

Interface
REQ-001 The module SHALL have a single clock `clk_in` and a synchronous, active-high reset `rst_in`.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- START_X, 1960, x position after reset.
- START_Y, 1960, y position after reset.
- MAX_SPEED, 12, road speed cap.
- OFFROAD_MAX, 4, grass speed cap.
- TERRAIN_TIMEOUT, 16, cycles to wait for terrain_valid_in.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk_in, in, 1, clock.
- rst_in, in, 1, synchronous active-high reset.
- frame_tick_in, in, 1, one-cycle pulse per video frame.
- gas_in, in, 1, accelerate.
- brake_in, in, 1, decelerate.
- left_in, in, 1, steer counter-clockwise.
- right_in, in, 1, steer clockwise.
- boost_in, in, 1, boost request pulse.
- terrain_req_out, out, 1, terrain lookup request.
- terrain_x_out, out, 11, candidate x position.
- terrain_y_out, out, 11, candidate y position.
- terrain_valid_in, in, 1, terrain answer valid.
- terrain_in, in, 2, terrain code: 0 road, 1 grass, 2 wall, 3 finish.
- player_x, out, 11, committed x position, drives track_view.
- player_y, out, 11, committed y position, drives track_view.
- heading_out, out, 4, one of 16 directions; 0 is +x, increasing clockwise.
- speed_out, out, 5, current speed.
- lap_out, out, 2, completed laps, saturating at 3.
- pos_valid_out, out, 1, one-cycle pulse when the position is committed.
- boost_active_out, out, 1, boost in effect.

Function
REQ-004 The FSM SHALL have the states IDLE, STEER, ACCEL, PROPOSE, WAIT_T and COMMIT, and each non-wait state SHALL last exactly one cycle.
REQ-005 In IDLE, frame_tick_in SHALL move the FSM to STEER, and frame_tick_in arriving in any other state SHALL be ignored.
REQ-006 In STEER, left_in alone SHALL decrement heading_out mod 16, right_in alone SHALL increment it mod 16, and both or neither SHALL leave it unchanged.
REQ-007 In ACCEL, speed SHALL update as follows:
- gas_in alone: +1.
- brake_in alone: -2, floored at 0.
- both or neither: -1 (coasting), floored at 0.
- The result SHALL then be clamped to the active cap.
REQ-008 The active cap SHALL be MAX_SPEED on road or finish and OFFROAD_MAX on grass, using the terrain code committed for the previous frame.
REQ-009 In PROPOSE, the candidate position SHALL be computed as follows:
- cand = pos + ((vec[heading] * speed) >>> 3).
- vec is a signed 5-bit unit vector in [-8, 8].
- The sum SHALL use 13-bit signed arithmetic, clamped to [0, 2047].
REQ-010 terrain_req_out SHALL assert on entry to WAIT_T and hold until terrain_valid_in is seen or the timeout expires.
REQ-011 terrain_x_out and terrain_y_out SHALL be held stable while terrain_req_out is high.
REQ-012 If terrain_valid_in is not seen within TERRAIN_TIMEOUT cycles of WAIT_T entry, the terrain SHALL be treated as wall.
REQ-013 terrain_valid_in arriving outside WAIT_T SHALL be ignored.
REQ-014 In COMMIT, on wall the position SHALL be unchanged and speed set to 0; on any other terrain, player_x/player_y SHALL take the candidate position.
REQ-015 lap_out SHALL increment (saturating at 3) only on a commit whose terrain is finish when the previous committed terrain was not finish.
REQ-016 pos_valid_out SHALL pulse in the COMMIT cycle, and the FSM SHALL return to IDLE on the next cycle.
REQ-017 Latency from frame_tick_in to pos_valid_out SHALL be 4 + N cycles, where N is the number of WAIT_T cycles (N >= 1).
REQ-018 At speed 0, the candidate SHALL equal the current position and a lookup SHALL still be issued.

Reset
REQ-019 While rst_in is high, the outputs SHALL take these values:
- player_x = START_X, player_y = START_Y.
- heading_out = 0, speed_out = 0, lap_out = 0.
- terrain_req_out = 0, pos_valid_out = 0, boost_active_out = 0.
- Previous-terrain register = road.
- FSM = IDLE.
REQ-020 Reset asserted mid-operation, including in WAIT_T, SHALL abandon the frame with no commit, and the first frame_tick_in after release SHALL start a fresh update.

Configuration
REQ-021 With KART_BOOST_EN defined, a boost_in pulse SHALL behave as follows:
- Set boost_active_out for 64 frame_tick_in pulses.
- Raise the road cap to MAX_SPEED+4.
- Add +2 in ACCEL.
- A boost_in while already active SHALL restart the count.
REQ-022 Without KART_BOOST_EN, boost_in SHALL be ignored, boost_active_out SHALL be constant 0, and no boost counter SHALL be synthesized.

Structure
REQ-023 Package kart_pkg SHALL hold the terrain_t enum, the physics-state enum, and the WORLD_MAX=2047 constant.
REQ-024 Sub-module heading_lut SHALL map the 4-bit heading to signed 5-bit (vx, vy) combinationally.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then one tick with no inputs and road terrain -> pos_valid_out pulses, position (1960, 1960), speed 0.
- gas_in held, 20 ticks, heading 0, road -> speed saturates at 12, x increases by 12 per frame once saturated.
- Speed 12, heading 0, lookup returns wall -> position unchanged, speed_out = 0 after commit.
- Grass committed, then gas_in held -> speed capped at 4; terrain_valid_in withheld for 20 cycles -> treated as wall, pos_valid_out at cycle 4 + 16.
- Terrain sequence road, finish, finish, road, finish -> lap_out goes 0, 1, 1, 1, 2; five laps -> lap_out = 3.
- rst_in pulsed during WAIT_T -> no pos_valid_out, outputs at reset values; with KART_BOOST_EN, boost_in -> speed 16 on road, boost_active_out drops after 64 ticks.
